// File: rtl/ppt_regbank_mc.sv
// rtl/ppt_regbank_mc.sv - byte-wide double-buffered register bank for NUM_CH PPT channels
module ppt_regbank_mc #(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 6,
  parameter int DIV_W  = 5
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [ADDR_W-1:0]       address,
  input  logic [7:0]              data_in,
  input  logic                    write_enable,
  input  logic                    read_enable,
  output logic [7:0]              data_out,
  output logic [NUM_CH*DIV_W-1:0] clk_div,
  output logic [NUM_CH*16-1:0]    period,
  output logic [NUM_CH*16-1:0]    width,
  output logic [NUM_CH*16-1:0]    count,
  output logic [NUM_CH-1:0]       run_ppt,
  input  logic [NUM_CH*16-1:0]    count_done,
  input  logic [NUM_CH-1:0]       done,
  output logic                    irq
);
  localparam int WIN_W = ADDR_W - 4;

  logic [WIN_W-1:0] win;
  logic [3:0]       off;
  logic             glb_wr;

  assign win    = address[ADDR_W-1:4];
  assign off    = address[3:0];
  assign glb_wr = write_enable && (win == '0);

  logic [DIV_W-1:0]  sh_div_q  [NUM_CH];
  logic [DIV_W-1:0]  sh_div_d  [NUM_CH];
  logic [15:0]       sh_per_q  [NUM_CH];
  logic [15:0]       sh_per_d  [NUM_CH];
  logic [15:0]       sh_wid_q  [NUM_CH];
  logic [15:0]       sh_wid_d  [NUM_CH];
  logic [15:0]       sh_cnt_q  [NUM_CH];
  logic [15:0]       sh_cnt_d  [NUM_CH];
  logic [DIV_W-1:0]  act_div_q [NUM_CH];
  logic [DIV_W-1:0]  act_div_d [NUM_CH];
  logic [15:0]       act_per_q [NUM_CH];
  logic [15:0]       act_per_d [NUM_CH];
  logic [15:0]       act_wid_q [NUM_CH];
  logic [15:0]       act_wid_d [NUM_CH];
  logic [15:0]       act_cnt_q [NUM_CH];
  logic [15:0]       act_cnt_d [NUM_CH];
  logic [7:0]        snap_q    [NUM_CH];
  logic [7:0]        snap_d    [NUM_CH];
  logic [NUM_CH-1:0] sh_run_q, sh_run_d;
  logic [NUM_CH-1:0] act_run_q, act_run_d;
  logic [NUM_CH-1:0] done_q, done_d;
  logic [NUM_CH-1:0] irq_status_q, irq_status_d;
  logic [7:0]        irq_en_q, irq_en_d;
  logic              irq_q, irq_d;

  // Next state: shadow writes, commits, high-byte snapshots, sticky done flags, irq
  always_comb begin
    sh_div_d  = sh_div_q;
    sh_per_d  = sh_per_q;
    sh_wid_d  = sh_wid_q;
    sh_cnt_d  = sh_cnt_q;
    sh_run_d  = sh_run_q;
    act_div_d = act_div_q;
    act_per_d = act_per_q;
    act_wid_d = act_wid_q;
    act_cnt_d = act_cnt_q;
    act_run_d = act_run_q;
    snap_d    = snap_q;
    irq_en_d  = irq_en_q;
    done_d    = done;
    // irq reflects the status as it stood before this edge, hence the one-cycle lag
    irq_d     = |(irq_status_q & irq_en_q[NUM_CH-1:0]);
    irq_status_d = irq_status_q;
    if (glb_wr && off == 4'h1) irq_status_d = irq_status_d & ~data_in[NUM_CH-1:0];
    // rise applied after the clear so a simultaneous set wins
    irq_status_d = irq_status_d | (done & ~done_q);
    if (glb_wr && off == 4'h2) irq_en_d = data_in;
    for (int n = 0; n < NUM_CH; n++) begin
      if (write_enable && win == WIN_W'(n + 1)) begin
        case (off)
          4'h0: sh_div_d[n]       = data_in[DIV_W-1:0];
          4'h1: sh_per_d[n][7:0]  = data_in;
          4'h2: sh_per_d[n][15:8] = data_in;
          4'h3: sh_wid_d[n][7:0]  = data_in;
          4'h4: sh_wid_d[n][15:8] = data_in;
          4'h5: sh_cnt_d[n][7:0]  = data_in;
          4'h6: sh_cnt_d[n][15:8] = data_in;
          4'h7: sh_run_d[n]       = data_in[0];
          default: ;
        endcase
      end
      if (glb_wr && off == 4'h3 && data_in[n]) begin
        act_div_d[n] = sh_div_q[n];
        act_per_d[n] = sh_per_q[n];
        act_wid_d[n] = sh_wid_q[n];
        act_cnt_d[n] = sh_cnt_q[n];
        act_run_d[n] = sh_run_q[n];
      end
      if (read_enable && win == WIN_W'(n + 1) && off == 4'h8)
        snap_d[n] = count_done[n*16+8 +: 8];
    end
  end

  // State registers with asynchronous return to power-on defaults
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int n = 0; n < NUM_CH; n++) begin
        sh_div_q[n]  <= DIV_W'(9);
        sh_per_q[n]  <= 16'd128;
        sh_wid_q[n]  <= 16'd1;
        sh_cnt_q[n]  <= 16'd16;
        act_div_q[n] <= DIV_W'(9);
        act_per_q[n] <= 16'd128;
        act_wid_q[n] <= 16'd1;
        act_cnt_q[n] <= 16'd16;
        snap_q[n]    <= 8'h00;
      end
      sh_run_q     <= '0;
      act_run_q    <= '0;
      done_q       <= '0;
      irq_status_q <= '0;
      irq_en_q     <= 8'h00;
      irq_q        <= 1'b0;
    end else begin
      sh_div_q     <= sh_div_d;
      sh_per_q     <= sh_per_d;
      sh_wid_q     <= sh_wid_d;
      sh_cnt_q     <= sh_cnt_d;
      act_div_q    <= act_div_d;
      act_per_q    <= act_per_d;
      act_wid_q    <= act_wid_d;
      act_cnt_q    <= act_cnt_d;
      snap_q       <= snap_d;
      sh_run_q     <= sh_run_d;
      act_run_q    <= act_run_d;
      done_q       <= done_d;
      irq_status_q <= irq_status_d;
      irq_en_q     <= irq_en_d;
      irq_q        <= irq_d;
    end
  end

  // Read mux: shadow copies for config, live low byte plus snapshot for COUNT_DONE
  always_comb begin
    data_out = 8'h00;
    if (win == '0) begin
      case (off)
        4'h0: data_out = 8'hA5;
        4'h1: data_out = 8'(irq_status_q);
        4'h2: data_out = irq_en_q;
        default: ;
      endcase
    end
    for (int n = 0; n < NUM_CH; n++) begin
      if (win == WIN_W'(n + 1)) begin
        case (off)
          4'h0: data_out = 8'(sh_div_q[n]);
          4'h1: data_out = sh_per_q[n][7:0];
          4'h2: data_out = sh_per_q[n][15:8];
          4'h3: data_out = sh_wid_q[n][7:0];
          4'h4: data_out = sh_wid_q[n][15:8];
          4'h5: data_out = sh_cnt_q[n][7:0];
          4'h6: data_out = sh_cnt_q[n][15:8];
          4'h7: data_out = {7'b0, sh_run_q[n]};
          4'h8: data_out = count_done[n*16 +: 8];
          4'h9: data_out = snap_q[n];
          4'hA: data_out = {6'b0, act_run_q[n], done_q[n]};
          default: ;
        endcase
      end
    end
  end

  // Flatten the active copies onto the channel buses
  always_comb begin
    clk_div = '0;
    period  = '0;
    width   = '0;
    count   = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      clk_div[n*DIV_W +: DIV_W] = act_div_q[n];
      period[n*16 +: 16]        = act_per_q[n];
      width[n*16 +: 16]         = act_wid_q[n];
      count[n*16 +: 16]         = act_cnt_q[n];
    end
  end

  assign run_ppt = act_run_q;
  assign irq     = irq_q;
endmodule

// File: tb/tb_ppt_regbank_mc.sv
// tb/tb_ppt_regbank_mc.sv - randomized self-checking bench for ppt_regbank_mc
module tb_ppt_regbank_mc;
  localparam int NUM_CH = 2;
  localparam int ADDR_W = 6;
  localparam int DIV_W  = 5;
  localparam int DFLT [8] = '{9, 128, 0, 1, 0, 16, 0, 0};

  logic                    clk = 1'b0;
  logic                    rstn = 1'b0;
  logic [ADDR_W-1:0]       address = '0;
  logic [7:0]              data_in = '0;
  logic                    write_enable = 1'b0;
  logic                    read_enable = 1'b0;
  logic [7:0]              data_out;
  logic [NUM_CH*DIV_W-1:0] clk_div;
  logic [NUM_CH*16-1:0]    period, width, count;
  logic [NUM_CH*16-1:0]    count_done = '0;
  logic [NUM_CH-1:0]       run_ppt;
  logic [NUM_CH-1:0]       done = '0;
  logic                    irq;

  always #5 clk = ~clk;

  ppt_regbank_mc #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DIV_W(DIV_W)) dut (
    .clk(clk), .rstn(rstn), .address(address), .data_in(data_in),
    .write_enable(write_enable), .read_enable(read_enable), .data_out(data_out),
    .clk_div(clk_div), .period(period), .width(width), .count(count),
    .run_ppt(run_ppt), .count_done(count_done), .done(done), .irq(irq)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: shadow kept as a byte image of the address map, active as per-channel bytes
  int sh [64];
  int act [NUM_CH][8];
  int snap [NUM_CH];
  int st, en, dprev;
  bit irq_m;

  function automatic void model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      for (int k = 0; k < 8; k++) begin
        sh[16*(c+1)+k] = DFLT[k];
        act[c][k] = DFLT[k];
      end
      snap[c] = 0;
    end
    st = 0; en = 0; dprev = 0; irq_m = 0;
  endfunction

  function automatic int model_read(input int a);
    int w = a / 16;
    int o = a % 16;
    int c = w - 1;
    if (w == 0) begin
      if (o == 0) return 'hA5;
      if (o == 1) return st;
      if (o == 2) return en;
      return 0;
    end
    if (w > NUM_CH) return 0;
    if (o < 8) return sh[a];
    if (o == 8) return int'(count_done[c*16 +: 8]);
    if (o == 9) return snap[c];
    if (o == 10) return ((act[c][7] & 1) << 1) | ((dprev >> c) & 1);
    return 0;
  endfunction

  function automatic void model_step(input bit we, input bit re, input int a, input int din);
    int w = a / 16;
    int o = a % 16;
    int msk = (1 << NUM_CH) - 1;
    int dv = int'(done);
    int rise = dv & ~dprev & msk;
    int clr = 0;
    irq_m = (st & en & msk) != 0;
    if (we) begin
      if (a == 1) clr = din;
      else if (a == 2) en = din;
      else if (a == 3) begin
        for (int c = 0; c < NUM_CH; c++)
          if ((din >> c) & 1)
            for (int k = 0; k < 8; k++) act[c][k] = sh[16*(c+1)+k];
      end else if (w >= 1 && w <= NUM_CH && o < 8) begin
        if (o == 0) sh[a] = din % (1 << DIV_W);
        else if (o == 7) sh[a] = din & 1;
        else sh[a] = din;
      end
    end
    if (re && w >= 1 && w <= NUM_CH && o == 8)
      snap[w-1] = int'(count_done[(w-1)*16+8 +: 8]);
    st = ((st & ~clr) | rise) & msk;
    dprev = dv;
  endfunction

  task automatic check_outputs();
    for (int c = 0; c < NUM_CH; c++) begin
      chk("clk_div", 32'(clk_div[c*DIV_W +: DIV_W]), act[c][0]);
      chk("period", 32'(period[c*16 +: 16]), act[c][1] + 256 * act[c][2]);
      chk("width", 32'(width[c*16 +: 16]), act[c][3] + 256 * act[c][4]);
      chk("count", 32'(count[c*16 +: 16]), act[c][5] + 256 * act[c][6]);
      chk("run_ppt", 32'(run_ppt[c]), act[c][7] & 1);
    end
    chk("irq", 32'(irq), 32'(irq_m));
  endtask

  task automatic op(input bit we, input bit re, input int a, input int din);
    @(negedge clk);
    write_enable = we;
    read_enable = re;
    address = a[ADDR_W-1:0];
    data_in = din[7:0];
    #1 chk("data_out", 32'(data_out), model_read(a));
    @(posedge clk);
    model_step(we, re, a, din);
    #1 check_outputs();
    write_enable = 1'b0;
    read_enable = 1'b0;
  endtask

  task automatic async_reset();
    #2 rstn = 1'b0;
    write_enable = 1'b0;
    read_enable = 1'b0;
    address = 6'h10;
    #1 model_reset();
    check_outputs();
    chk("rst_clkdiv_rd", 32'(data_out), 32'h09);
    @(negedge clk) rstn = 1'b1;
  endtask

  initial begin
    int raddr [6] = '{'h10, 'h11, 'h13, 'h15, 'h17, 'h00};
    int rexp [6] = '{'h09, 'h80, 'h01, 'h10, 'h00, 'hA5};
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs();
    chk("rst_clkdiv0", 32'(clk_div[4:0]), 32'd9);
    chk("rst_period0", 32'(period[15:0]), 32'd128);
    for (int i = 0; i < 6; i++) begin
      address = raddr[i][ADDR_W-1:0];
      #1 chk("rst_read", 32'(data_out), rexp[i]);
    end
    @(negedge clk) rstn = 1'b1;

    // shadow write then commit of channel 1 only
    op(1, 0, 'h21, 'h34);
    op(1, 0, 'h22, 'h12);
    op(0, 1, 'h21, 0);
    chk("shadow_rd", 32'(data_out), 32'h34);
    chk("per1_precommit", 32'(period[31:16]), 32'd128);
    op(1, 0, 'h03, 'h02);
    chk("per1_commit", 32'(period[31:16]), 32'h1234);
    chk("per0_kept", 32'(period[15:0]), 32'd128);

    // atomic COUNT_DONE read
    count_done = 32'h0000_01FF;
    op(0, 1, 'h18, 0);
    chk("cd_lo", 32'(data_out), 32'hFF);
    count_done = 32'h0000_0200;
    op(0, 1, 'h19, 0);
    chk("cd_hi_snap", 32'(data_out), 32'h01);
    op(0, 1, 'h18, 0);
    chk("cd_lo2", 32'(data_out), 32'h00);
    op(0, 1, 'h19, 0);
    chk("cd_hi2", 32'(data_out), 32'h02);

    // done rise, irq lag, W1C, no re-set while held
    op(1, 0, 'h02, 'h01);
    done = 2'b01;
    op(0, 1, 'h01, 0);
    chk("irq_lag", 32'(irq), 32'd0);
    op(0, 1, 'h01, 0);
    chk("irq_set", 32'(irq), 32'd1);
    op(1, 0, 'h01, 'h01);
    op(0, 1, 'h01, 0);
    chk("irq_clr", 32'(irq), 32'd0);
    chk("status_clr", 32'(data_out), 32'h00);

    // set beats clear on ch1, masked from irq
    done = 2'b11;
    op(1, 0, 'h01, 'h02);
    op(0, 1, 'h01, 0);
    chk("set_wins", 32'(data_out), 32'h02);
    op(0, 0, 'h01, 0);
    chk("irq_masked", 32'(irq), 32'd0);

    // RUN commit then asynchronous reset mid-cycle
    op(1, 0, 'h17, 'h01);
    op(1, 0, 'h03, 'h01);
    chk("run_on", 32'(run_ppt), 32'd1);
    async_reset();
    chk("run_off", 32'(run_ppt), 32'd0);
    op(0, 1, 'h3B, 0);
    chk("unmapped_rd", 32'(data_out), 32'h00);
    op(1, 0, 'h3B, 'hFF);
    op(0, 1, 'h3B, 0);
    chk("unmapped_wr", 32'(data_out), 32'h00);

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      int r = int'($urandom_range(0, 19));
      int a = int'($urandom_range(0, 63));
      bit we = ($urandom_range(0, 2) == 0);
      bit re = ($urandom_range(0, 1) == 1);
      int din = int'($urandom_range(0, 255));
      if (r < 3) done = NUM_CH'($urandom);
      if (r == 3) count_done = 32'($urandom);
      if (r == 4) begin a = 3; we = 1; end
      if (r == 5) begin a = 16 * int'($urandom_range(1, NUM_CH)) + 8; re = 1; we = 0; end
      if (r == 6) begin a = int'($urandom_range(1, 2)); we = 1; end
      if (i % 200 == 199) async_reset();
      op(we, re, a, din);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
